reorder_buffer: RTL and testbench

Circular in-order retirement queue between the decoder/issue stage and the register file.
- Allocates one entry per issued instruction and collects results from the common data bus (CDB).
- Retires entries in program order, driving the register file commit port (reg id, data, rob id).
- Serves the register file's two dependency-lookup ports.
- Detects branch mispredictions at retirement and raises a one-cycle flush with the redirect PC.

---
 rtl/reorder_buffer_if.sv | 54 +++++
 rtl/reorder_buffer.sv | 123 ++++++++++++
 tb/tb_reorder_buffer.sv | 507 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Reorder buffer bus: issue, CDB writeback, dependency lookup and commit/flush.
// master drives issue/writeback/lookup ids; slave is the reorder buffer.
interface reorder_buffer_if #(
  parameter int ROB_WIDTH = 3,
  parameter int REG_WIDTH = 5
);
  logic                 issue_valid;
  logic [REG_WIDTH-1:0] issue_dest;
  logic                 issue_is_branch;
  logic                 issue_pred_taken;
  logic [31:0]          issue_alt_pc;
  logic [ROB_WIDTH-1:0] issue_rob_id;
  logic                 full;

  logic                 wb_valid;
  logic [ROB_WIDTH-1:0] wb_rob_id;
  logic [31:0]          wb_data;
  logic                 wb_taken;

  logic [ROB_WIDTH-1:0] rob_id_j;
  logic [ROB_WIDTH-1:0] rob_id_k;
  logic                 ready_j;
  logic [31:0]          data_j;
  logic                 ready_k;
  logic [31:0]          data_k;

  logic [REG_WIDTH-1:0] commit_reg_id;
  logic [31:0]          commit_data;
  logic [ROB_WIDTH-1:0] commit_rob_id;
  logic                 flush;
  logic [31:0]          flush_pc;

  modport master (
    output issue_valid, issue_dest, issue_is_branch,
    output issue_pred_taken, issue_alt_pc,
    output wb_valid, wb_rob_id, wb_data, wb_taken,
    output rob_id_j, rob_id_k,
    input  issue_rob_id, full,
    input  ready_j, data_j, ready_k, data_k,
    input  commit_reg_id, commit_data, commit_rob_id,
    input  flush, flush_pc
  );

  modport slave (
    input  issue_valid, issue_dest, issue_is_branch,
    input  issue_pred_taken, issue_alt_pc,
    input  wb_valid, wb_rob_id, wb_data, wb_taken,
    input  rob_id_j, rob_id_k,
    output issue_rob_id, full,
    output ready_j, data_j, ready_k, data_k,
    output commit_reg_id, commit_data, commit_rob_id,
    output flush, flush_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// Reorder buffer: circular in-order retirement queue feeding the register file.
// Collects CDB results, serves two lookups, flushes on mispredicted branches.
module reorder_buffer #(
  parameter int ROB_WIDTH = 3,
  parameter int REG_WIDTH = 5
) (
  input logic             clk_in,
  input logic             rst_in,
  input logic             rdy_in,
  reorder_buffer_if.slave rob
);
  localparam int ROB_SIZE = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] FULL_CNT = (ROB_WIDTH+1)'(ROB_SIZE);

  logic [ROB_SIZE-1:0]  busy;
  logic [ROB_SIZE-1:0]  done;
  logic [ROB_SIZE-1:0]  is_br;
  logic [ROB_SIZE-1:0]  pred;
  logic [ROB_SIZE-1:0]  tkn;
  logic [REG_WIDTH-1:0] dest   [ROB_SIZE];
  logic [31:0]          data   [ROB_SIZE];
  logic [31:0]          alt_pc [ROB_SIZE];

  logic [ROB_WIDTH-1:0] head;
  logic [ROB_WIDTH-1:0] tail;
  logic [ROB_WIDTH:0]   count;

  logic full_w;
  logic issue_ok;
  logic wb_ok;
  logic retire;
  logic mispred;

  assign full_w           = count == FULL_CNT;
  assign rob.full         = full_w;
  assign rob.issue_rob_id = tail;

  assign issue_ok = rdy_in && rob.issue_valid && !full_w && !rob.flush;
  assign wb_ok    = rdy_in && rob.wb_valid && !rob.flush
                 && busy[rob.wb_rob_id];
  assign retire   = rdy_in && !rob.flush && busy[head] && done[head];
  assign mispred  = retire && is_br[head] && (tkn[head] != pred[head]);

  // Same-cycle CDB result wins over the stored value.
  always_comb begin
    rob.ready_j = done[rob.rob_id_j];
    rob.data_j  = data[rob.rob_id_j];
    rob.ready_k = done[rob.rob_id_k];
    rob.data_k  = data[rob.rob_id_k];
    if (rob.wb_valid && rob.wb_rob_id == rob.rob_id_j) begin
      rob.ready_j = 1'b1;
      rob.data_j  = rob.wb_data;
    end
    if (rob.wb_valid && rob.wb_rob_id == rob.rob_id_k) begin
      rob.ready_k = 1'b1;
      rob.data_k  = rob.wb_data;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
      done  <= '0;
      is_br <= '0;
      pred  <= '0;
      tkn   <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        dest[i]   <= '0;
        data[i]   <= '0;
        alt_pc[i] <= '0;
      end
      rob.commit_reg_id <= '0;
      rob.commit_data   <= '0;
      rob.commit_rob_id <= '0;
      rob.flush         <= 1'b0;
      rob.flush_pc      <= '0;
    end else if (rdy_in) begin
      if (issue_ok) begin
        busy[tail]   <= 1'b1;
        done[tail]   <= 1'b0;
        dest[tail]   <= rob.issue_dest;
        is_br[tail]  <= rob.issue_is_branch;
        pred[tail]   <= rob.issue_pred_taken;
        alt_pc[tail] <= rob.issue_alt_pc;
        tail         <= tail + 1'b1;
      end
      if (wb_ok) begin
        done[rob.wb_rob_id] <= 1'b1;
        data[rob.wb_rob_id] <= rob.wb_data;
        tkn[rob.wb_rob_id]  <= rob.wb_taken;
      end
      if (retire) begin
        busy[head]        <= 1'b0;
        head              <= head + 1'b1;
        rob.commit_reg_id <= dest[head];
        rob.commit_data   <= data[head];
        rob.commit_rob_id <= head;
      end else begin
        rob.commit_reg_id <= '0;
      end
      unique case ({issue_ok, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      rob.flush <= mispred;
      // A mispredict squashes everything younger, including this cycle's issue.
      if (mispred) begin
        rob.flush_pc      <= alt_pc[head];
        head              <= '0;
        tail              <= '0;
        count             <= '0;
        busy              <= '0;
        rob.commit_reg_id <= '0;
        rob.commit_data   <= '0;
        rob.commit_rob_id <= '0;
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer: directed scenarios plus randomized traffic
// checked against a program-order queue model.
module tb_reorder_buffer;
  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;

  reorder_buffer_if #(.ROB_WIDTH(3), .REG_WIDTH(5)) bus ();

  reorder_buffer #(.ROB_WIDTH(3), .REG_WIDTH(5)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .rob   (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          id;
    logic [4:0]  dest;
    bit          br;
    bit          pt;
    bit          tk;
    bit          rdy;
    logic [31:0] data;
    logic [31:0] alt;
  } ent_t;

  ent_t        q[$];
  int          m_tail;
  bit          m_flush;
  logic [31:0] m_fpc;
  logic [4:0]  m_creg;
  logic [31:0] m_cdata;
  logic [2:0]  m_crob;
  bit          m_ready [8];
  logic [31:0] m_data  [8];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic model_reset();
    q.delete();
    m_tail  = 0;
    m_flush = 0;
    m_fpc   = '0;
    m_creg  = '0;
    m_cdata = '0;
    m_crob  = '0;
    for (int i = 0; i < 8; i++) begin
      m_ready[i] = 0;
      m_data[i]  = '0;
    end
  endtask

  // One clock edge of the reference: program-order queue semantics.
  task automatic model_edge();
    bit   ret;
    bit   mis;
    ent_t h;
    int   n;
    n   = q.size();
    ret = !m_flush && n > 0 && q[0].rdy;
    mis = 0;
    if (ret) begin
      h   = q[0];
      mis = h.br && (h.tk != h.pt);
    end
    if (!m_flush && bus.wb_valid) begin
      foreach (q[i]) begin
        if (q[i].id == int'(bus.wb_rob_id)) begin
          q[i].rdy  = 1;
          q[i].data = bus.wb_data;
          q[i].tk   = bus.wb_taken;
          m_ready[q[i].id] = 1;
          m_data[q[i].id]  = bus.wb_data;
        end
      end
    end
    if (!m_flush && bus.issue_valid && n < 8) begin
      q.push_back('{m_tail, bus.issue_dest, bus.issue_is_branch,
                    bus.issue_pred_taken, 1'b0, 1'b0, 32'h0,
                    bus.issue_alt_pc});
      m_ready[m_tail] = 0;
      m_tail = (m_tail + 1) % 8;
    end
    if (ret) void'(q.pop_front());
    m_flush = mis;
    if (mis) begin
      m_fpc   = h.alt;
      q.delete();
      m_tail  = 0;
      m_creg  = '0;
      m_cdata = '0;
      m_crob  = '0;
    end else if (ret) begin
      m_creg  = h.dest;
      m_cdata = h.data;
      m_crob  = 3'(h.id);
    end else begin
      m_creg  = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    if (!rst_in && rdy_in) model_edge();
    #1;
  endtask

  task automatic idle();
    bus.issue_valid      = 0;
    bus.issue_dest       = '0;
    bus.issue_is_branch  = 0;
    bus.issue_pred_taken = 0;
    bus.issue_alt_pc     = '0;
    bus.wb_valid         = 0;
    bus.wb_rob_id        = '0;
    bus.wb_data          = '0;
    bus.wb_taken         = 0;
    bus.rob_id_j         = '0;
    bus.rob_id_k         = '0;
  endtask

  task automatic do_reset();
    idle();
    rdy_in = 1;
    rst_in = 1;
    model_reset();
    tick();
    rst_in = 0;
  endtask

  task automatic test_reset();
    idle();
    rdy_in = 1;
    rst_in = 1;
    model_reset();
    #1;
    n_cmp++;
    if (bus.commit_reg_id !== 5'd0 || bus.commit_rob_id !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_commit_ids got=%0h/%0h exp=0/0",
               bus.commit_reg_id, bus.commit_rob_id);
    end
    n_cmp++;
    if (bus.commit_data !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_commit_data got=%0h exp=0", bus.commit_data);
    end
    n_cmp++;
    if (bus.flush !== 1'b0 || bus.flush_pc !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_flush got=%0b/%0h exp=0/0",
               bus.flush, bus.flush_pc);
    end
    n_cmp++;
    if (bus.issue_rob_id !== 3'd0 || bus.full !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ptr got=%0d/%0b exp=0/0",
               bus.issue_rob_id, bus.full);
    end
    tick();
    tick();
    rst_in = 0;
  endtask

  task automatic test_in_order();
    logic [2:0]  ids [3];
    logic [31:0] dat [3];
    ids = '{3'd2, 3'd0, 3'd1};
    dat = '{32'h30, 32'h10, 32'h20};
    do_reset();
    bus.issue_valid = 1;
    for (int i = 0; i < 3; i++) begin
      bus.issue_dest = 5'(i + 1);
      n_cmp++;
      if (bus.issue_rob_id !== 3'(i)) begin
        n_bad++;
        $display("FAIL inord_issue_id got=%0d exp=%0d", bus.issue_rob_id, i);
      end
      tick();
    end
    idle();
    n_cmp++;
    if (bus.full !== 1'b0 || bus.commit_reg_id !== 5'd0) begin
      n_bad++;
      $display("FAIL inord_idle got full=%0b reg=%0d exp=0/0",
               bus.full, bus.commit_reg_id);
    end
    for (int i = 0; i < 3; i++) begin
      bus.wb_valid  = 1;
      bus.wb_rob_id = ids[i];
      bus.wb_data   = dat[i];
      tick();
      if (i == 1) begin
        n_cmp++;
        if (bus.commit_reg_id !== 5'd0) begin
          n_bad++;
          $display("FAIL inord_early got=%0d exp=0", bus.commit_reg_id);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bus.commit_reg_id !== 5'(i + 1) ||
          bus.commit_data !== 32'(16 * (i + 1)) ||
          bus.commit_rob_id !== 3'(i)) begin
        n_bad++;
        $display("FAIL inord_commit%0d got=%0d/%0h/%0d exp=%0d/%0h/%0d", i,
                 bus.commit_reg_id, bus.commit_data, bus.commit_rob_id,
                 i + 1, 16 * (i + 1), i);
      end
      idle();
      tick();
    end
    n_cmp++;
    if (bus.commit_reg_id !== 5'd0) begin
      n_bad++;
      $display("FAIL inord_drain got=%0d exp=0", bus.commit_reg_id);
    end
  endtask

  task automatic test_full();
    do_reset();
    bus.issue_valid = 1;
    for (int i = 0; i < 8; i++) begin
      bus.issue_dest = 5'(i + 1);
      tick();
    end
    n_cmp++;
    if (bus.full !== 1'b1 || bus.issue_rob_id !== 3'd0) begin
      n_bad++;
      $display("FAIL full_set got=%0b/%0d exp=1/0",
               bus.full, bus.issue_rob_id);
    end
    tick();
    n_cmp++;
    if (bus.full !== 1'b1 || bus.issue_rob_id !== 3'd0) begin
      n_bad++;
      $display("FAIL full_drop got=%0b/%0d exp=1/0",
               bus.full, bus.issue_rob_id);
    end
    bus.wb_valid  = 1;
    bus.wb_rob_id = 3'd0;
    bus.wb_data   = 32'hA0;
    tick();
    bus.wb_rob_id = 3'd1;
    bus.wb_data   = 32'hA1;
    tick();
    n_cmp++;
    if (bus.full !== 1'b0 || bus.commit_rob_id !== 3'd0 ||
        bus.issue_rob_id !== 3'd0) begin
      n_bad++;
      $display("FAIL full_retire got=%0b/%0d/%0d exp=0/0/0",
               bus.full, bus.commit_rob_id, bus.issue_rob_id);
    end
    bus.wb_valid = 0;
    tick();
    n_cmp++;
    if (bus.full !== 1'b0 || bus.issue_rob_id !== 3'd1 ||
        bus.commit_rob_id !== 3'd1 || bus.commit_data !== 32'hA1) begin
      n_bad++;
      $display("FAIL full_swap got=%0b/%0d/%0d/%0h exp=0/1/1/a1",
               bus.full, bus.issue_rob_id, bus.commit_rob_id,
               bus.commit_data);
    end
    tick();
    n_cmp++;
    if (bus.full !== 1'b1 || bus.issue_rob_id !== 3'd2) begin
      n_bad++;
      $display("FAIL full_refill got=%0b/%0d exp=1/2",
               bus.full, bus.issue_rob_id);
    end
    idle();
  endtask

  task automatic test_mispredict();
    do_reset();
    bus.issue_valid      = 1;
    bus.issue_is_branch  = 1;
    bus.issue_pred_taken = 0;
    bus.issue_alt_pc     = 32'h100;
    tick();
    bus.issue_is_branch  = 0;
    bus.issue_dest       = 5'd5;
    tick();
    bus.issue_dest       = 5'd6;
    tick();
    idle();
    bus.wb_valid  = 1;
    bus.wb_rob_id = 3'd0;
    bus.wb_taken  = 1;
    tick();
    idle();
    tick();
    n_cmp++;
    if (bus.flush !== 1'b1 || bus.flush_pc !== 32'h100) begin
      n_bad++;
      $display("FAIL misp_flush got=%0b/%0h exp=1/100",
               bus.flush, bus.flush_pc);
    end
    n_cmp++;
    if (bus.commit_reg_id !== 5'd0 || bus.commit_data !== 32'd0 ||
        bus.issue_rob_id !== 3'd0) begin
      n_bad++;
      $display("FAIL misp_state got=%0d/%0h/%0d exp=0/0/0",
               bus.commit_reg_id, bus.commit_data, bus.issue_rob_id);
    end
    bus.issue_valid = 1;
    bus.issue_dest  = 5'd9;
    bus.wb_valid    = 1;
    bus.wb_rob_id   = 3'd1;
    tick();
    idle();
    n_cmp++;
    if (bus.flush !== 1'b0 || bus.issue_rob_id !== 3'd0 ||
        bus.full !== 1'b0) begin
      n_bad++;
      $display("FAIL misp_after got=%0b/%0d/%0b exp=0/0/0",
               bus.flush, bus.issue_rob_id, bus.full);
    end
    bus.issue_valid      = 1;
    bus.issue_is_branch  = 1;
    bus.issue_pred_taken = 1;
    bus.issue_alt_pc     = 32'h200;
    tick();
    idle();
    bus.wb_valid  = 1;
    bus.wb_rob_id = 3'd0;
    bus.wb_taken  = 1;
    tick();
    idle();
    tick();
    n_cmp++;
    if (bus.flush !== 1'b0 || bus.commit_reg_id !== 5'd0 ||
        bus.issue_rob_id !== 3'd1) begin
      n_bad++;
      $display("FAIL good_branch got=%0b/%0d/%0d exp=0/0/1",
               bus.flush, bus.commit_reg_id, bus.issue_rob_id);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    bus.issue_valid = 1;
    for (int i = 0; i < 5; i++) begin
      bus.issue_dest = 5'(i + 10);
      tick();
    end
    idle();
    bus.rob_id_j  = 3'd4;
    bus.rob_id_k  = 3'd3;
    bus.wb_valid  = 1;
    bus.wb_rob_id = 3'd4;
    bus.wb_data   = 32'hDEAD;
    #1;
    n_cmp++;
    if (bus.ready_j !== 1'b1 || bus.data_j !== 32'hDEAD) begin
      n_bad++;
      $display("FAIL byp_j got=%0b/%0h exp=1/dead", bus.ready_j, bus.data_j);
    end
    n_cmp++;
    if (bus.ready_k !== 1'b0) begin
      n_bad++;
      $display("FAIL byp_k got=%0b exp=0", bus.ready_k);
    end
    tick();
    bus.wb_valid = 0;
    #1;
    n_cmp++;
    if (bus.ready_j !== 1'b1 || bus.data_j !== 32'hDEAD) begin
      n_bad++;
      $display("FAIL byp_stored got=%0b/%0h exp=1/dead",
               bus.ready_j, bus.data_j);
    end
    idle();
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.issue_valid = 1;
    for (int i = 0; i < 6; i++) begin
      bus.issue_dest = 5'(i + 1);
      tick();
    end
    idle();
    bus.wb_valid  = 1;
    bus.wb_rob_id = 3'd0;
    bus.wb_data   = 32'h55;
    tick();
    idle();
    tick();
    n_cmp++;
    if (bus.commit_reg_id !== 5'd1 || bus.commit_data !== 32'h55) begin
      n_bad++;
      $display("FAIL arst_pre got=%0d/%0h exp=1/55",
               bus.commit_reg_id, bus.commit_data);
    end
    #2;
    rst_in = 1;
    model_reset();
    #1;
    n_cmp++;
    if (bus.commit_reg_id !== 5'd0 || bus.commit_data !== 32'd0 ||
        bus.issue_rob_id !== 3'd0 || bus.full !== 1'b0 ||
        bus.flush !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_clear got=%0d/%0h/%0d/%0b/%0b exp=0",
               bus.commit_reg_id, bus.commit_data, bus.issue_rob_id,
               bus.full, bus.flush);
    end
    rst_in = 0;
    tick();
    bus.issue_valid = 1;
    bus.issue_dest  = 5'd7;
    tick();
    idle();
    n_cmp++;
    if (bus.issue_rob_id !== 3'd1) begin
      n_bad++;
      $display("FAIL arst_first got=%0d exp=1", bus.issue_rob_id);
    end
  endtask

  task automatic test_random();
    bit          hj;
    bit          hk;
    bit          er;
    logic [31:0] ed;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rdy_in               = ($urandom_range(9) != 0);
      bus.issue_valid      = ($urandom_range(2) != 0);
      bus.issue_is_branch  = ($urandom_range(3) == 0);
      bus.issue_dest       = bus.issue_is_branch ? 5'd0 : 5'($urandom);
      bus.issue_pred_taken = 1'($urandom);
      bus.issue_alt_pc     = $urandom;
      bus.wb_valid         = 1'($urandom);
      if (q.size() > 0 && $urandom_range(3) != 0)
        bus.wb_rob_id = 3'(q[$urandom_range(q.size() - 1)].id);
      else
        bus.wb_rob_id = 3'($urandom);
      bus.wb_data  = $urandom;
      bus.wb_taken = 1'($urandom);
      bus.rob_id_j = 3'($urandom);
      bus.rob_id_k = 3'($urandom);
      #1;
      hj = bus.wb_valid && bus.wb_rob_id == bus.rob_id_j;
      hk = bus.wb_valid && bus.wb_rob_id == bus.rob_id_k;
      er = m_ready[bus.rob_id_j] || hj;
      ed = hj ? bus.wb_data : m_data[bus.rob_id_j];
      n_cmp++;
      if (bus.ready_j !== er || bus.data_j !== ed) begin
        n_bad++;
        $display("FAIL rnd_look_j cyc=%0d got=%0b/%0h exp=%0b/%0h",
                 c, bus.ready_j, bus.data_j, er, ed);
      end
      er = m_ready[bus.rob_id_k] || hk;
      ed = hk ? bus.wb_data : m_data[bus.rob_id_k];
      n_cmp++;
      if (bus.ready_k !== er || bus.data_k !== ed) begin
        n_bad++;
        $display("FAIL rnd_look_k cyc=%0d got=%0b/%0h exp=%0b/%0h",
                 c, bus.ready_k, bus.data_k, er, ed);
      end
      tick();
      n_cmp++;
      if (bus.issue_rob_id !== 3'(m_tail) ||
          bus.full !== (q.size() == 8)) begin
        n_bad++;
        $display("FAIL rnd_ptr cyc=%0d got=%0d/%0b exp=%0d/%0b",
                 c, bus.issue_rob_id, bus.full, m_tail, q.size() == 8);
      end
      n_cmp++;
      if (bus.commit_reg_id !== m_creg || bus.commit_data !== m_cdata ||
          bus.commit_rob_id !== m_crob) begin
        n_bad++;
        $display("FAIL rnd_commit cyc=%0d got=%0d/%0h/%0d exp=%0d/%0h/%0d",
                 c, bus.commit_reg_id, bus.commit_data, bus.commit_rob_id,
                 m_creg, m_cdata, m_crob);
      end
      n_cmp++;
      if (bus.flush !== m_flush || (m_flush && bus.flush_pc !== m_fpc)) begin
        n_bad++;
        $display("FAIL rnd_flush cyc=%0d got=%0b/%0h exp=%0b/%0h",
                 c, bus.flush, bus.flush_pc, m_flush, m_fpc);
      end
    end
    rdy_in = 1;
    idle();
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full();
    test_mispredict();
    test_bypass();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
